// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port byte-addressable memory behind a valid/ready
// request/response pair. One request is processed at a time. A request is
// accepted, waits a fixed number of cycles, and then performs the access.
// The response is then held until the consumer takes it.
//
// Handshake: a request transfers on a rising edge where i_req_valid and
// o_req_ready are both 1. A response transfers on a rising edge where
// o_resp_valid and i_resp_ready are both 1. Once o_resp_valid is raised, it
// stays high with o_resp_rdata and o_resp_err stable until that transfer.
// o_state exposes the FSM state (0 = IDLE, 1 = BUSY, 2 = RESP) for debug.
module mem_ctrl #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic              i_req_signed,
  input  logic [1:0]        i_req_size,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic [1:0]        o_state
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;
  logic                r_wen;
  logic                r_signed;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  // Storage is never reset; its contents are undefined until written.
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [LANE_W-1:0]   w_lane;
  logic [IDX_W-1:0]    w_idx;
  logic                w_upper_nz;
  logic                w_misalign;
  logic                w_bad_size;
  logic                w_err;
  logic [3:0]          w_nbytes;
  logic [NB-1:0]       w_be;
  logic [DATA_W-1:0]   w_wdata_sh;
  logic [DATA_W-1:0]   w_word;
  logic [DATA_W-1:0]   w_rd_sh;
  logic [DATA_W-1:0]   w_load;
  logic                w_access;
  logic                w_do_write;

  // Word index and byte lane come from the captured address. Any address bit
  // above the index field puts the access out of range.
  assign w_lane     = r_addr[LANE_W-1:0];
  assign w_idx      = r_addr[LANE_W +: IDX_W];
  assign w_upper_nz = |(r_addr >> (LANE_W + IDX_W));
  assign w_bad_size = (r_size == 2'd3) && (DATA_W == 32);
  assign w_err      = w_misalign | w_upper_nz | w_bad_size;
  assign w_nbytes   = 4'd1 << r_size;

  // The access happens on the last BUSY cycle. Stores write only when the
  // access is legal.
  assign w_access   = (r_state == S_BUSY) && (r_cnt == '0);
  assign w_do_write = w_access && r_wen && !w_err;

  // Alignment check: the address must be a multiple of the access size.
  always_comb begin
    w_misalign = 1'b0;
    case (r_size)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = r_addr[0];
      2'd2:    w_misalign = |r_addr[1:0];
      default: w_misalign = |r_addr[2:0];
    endcase
  end

  // Byte enables cover the accessed bytes, starting at the addressed lane.
  always_comb begin
    w_be = '0;
    for (int b = 0; b < NB; b++) begin
      w_be[b] = (b >= int'(w_lane)) && (b < int'(w_lane) + int'(w_nbytes));
    end
  end

  assign w_wdata_sh = r_wdata << {w_lane, 3'b000};
  assign w_word     = r_mem[w_idx];
  assign w_rd_sh    = w_word >> {w_lane, 3'b000};

  // Load result: right-aligned bytes, extended from the access MSB when signed.
  // A full-width access passes the word through unchanged.
  always_comb begin
    w_load = w_rd_sh;
    case (r_size)
      2'd0: begin
        if (r_signed) w_load = DATA_W'($signed(w_rd_sh[7:0]));
        else          w_load = DATA_W'(w_rd_sh[7:0]);
      end
      2'd1: begin
        if (r_signed) w_load = DATA_W'($signed(w_rd_sh[15:0]));
        else          w_load = DATA_W'(w_rd_sh[15:0]);
      end
      2'd2: begin
        if (r_signed) w_load = DATA_W'($signed(w_rd_sh[31:0]));
        else          w_load = DATA_W'(w_rd_sh[31:0]);
      end
      default: w_load = w_rd_sh;
    endcase
  end

  // Control FSM: accept in IDLE, count down in BUSY, hold the response in RESP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_wen        <= 1'b0;
      r_signed     <= 1'b0;
      r_size       <= 2'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (i_req_valid && r_req_ready) begin
            r_wen       <= i_req_wen;
            r_signed    <= i_req_signed;
            r_size      <= i_req_size;
            r_addr      <= i_req_addr;
            r_wdata     <= i_req_wdata;
            r_cnt       <= CNT_W'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_resp_rdata <= (w_err || r_wen) ? '0 : w_load;
          end
        end
        S_RESP: begin
          // Ready rises with the return to IDLE, so the earliest re-accept is
          // the edge after the response is consumed.
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage write on the BUSY-to-RESP edge. A reset during BUSY forces the
  // state to IDLE, so an aborted store never reaches the array.
  always_ff @(posedge i_clk) begin
    if (w_do_write) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
      end
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_state      = r_state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: three instances share a clock and reset.
//   d=0: DATA_W=64, LATENCY=2
//   d=1: DATA_W=32, LATENCY=1
//   d=2: DATA_W=32, LATENCY=4
// Table-driven transactions plus hand-written hold, back-pressure and reset
// sequences.
module tb_mem_ctrl;

  logic clk;
  logic rst_n;

  logic        req_valid  [3];
  logic        req_wen    [3];
  logic        req_signed [3];
  logic [1:0]  req_size   [3];
  logic [63:0] req_addr   [3];
  logic [63:0] req_wdata  [3];
  logic        resp_ready [3];

  logic        req_ready  [3];
  logic        resp_valid [3];
  logic        resp_err   [3];
  logic [63:0] resp_rdata [3];
  logic [1:0]  state      [3];

  logic [31:0] rdata_1;
  logic [31:0] rdata_2;

  int lat_of [3] = '{2, 1, 4};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    bit          wen;
    bit          sgn;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t v64 [$];
  vec_t v32 [$];

  mem_ctrl #(.ADDR_W(64), .DATA_W(64), .DEPTH(1024), .LATENCY(2)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_wen(req_wen[0]), .i_req_signed(req_signed[0]),
    .i_req_size(req_size[0]), .i_req_addr(req_addr[0]),
    .i_req_wdata(req_wdata[0]),
    .o_resp_valid(resp_valid[0]), .i_resp_ready(resp_ready[0]),
    .o_resp_rdata(resp_rdata[0]), .o_resp_err(resp_err[0]),
    .o_state(state[0])
  );

  mem_ctrl #(.ADDR_W(64), .DATA_W(32), .DEPTH(1024), .LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_wen(req_wen[1]), .i_req_signed(req_signed[1]),
    .i_req_size(req_size[1]), .i_req_addr(req_addr[1]),
    .i_req_wdata(req_wdata[1][31:0]),
    .o_resp_valid(resp_valid[1]), .i_resp_ready(resp_ready[1]),
    .o_resp_rdata(rdata_1), .o_resp_err(resp_err[1]),
    .o_state(state[1])
  );

  mem_ctrl #(.ADDR_W(64), .DATA_W(32), .DEPTH(1024), .LATENCY(4)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
    .i_req_wen(req_wen[2]), .i_req_signed(req_signed[2]),
    .i_req_size(req_size[2]), .i_req_addr(req_addr[2]),
    .i_req_wdata(req_wdata[2][31:0]),
    .o_resp_valid(resp_valid[2]), .i_resp_ready(resp_ready[2]),
    .o_resp_rdata(rdata_2), .o_resp_err(resp_err[2]),
    .o_state(state[2])
  );

  assign resp_rdata[1] = {32'd0, rdata_1};
  assign resp_rdata[2] = {32'd0, rdata_2};

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input bit wen, input bit sgn,
                              input logic [1:0] size, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] exp_rdata,
                              input bit exp_err);
    vec_t v;
    v.name = name; v.wen = wen; v.sgn = sgn; v.size = size; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  // Drive a request and wait for it to be accepted; returns #1 after the
  // accepting edge with valid already dropped.
  task automatic issue(input int d, input bit wen, input bit sgn, input logic [1:0] size,
                       input logic [63:0] addr, input logic [63:0] wdata);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1; req_wen[d] = wen; req_signed[d] = sgn;
    req_size[d] = size; req_addr[d] = addr; req_wdata[d] = wdata;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("req_ready_before_accept_d%0d", d), {63'd0, req_ready[d]}, 64'd1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    check($sformatf("busy_after_accept_d%0d", d), {62'd0, state[d]}, 64'd1);
  endtask

  // Count edges from acceptance until resp_valid; bounded.
  task automatic wait_resp(input int d);
    int lat;
    lat = 0;
    do begin
      if (lat != 0 || resp_valid[d] === 1'b0) begin
        @(posedge clk);
        #1;
        lat++;
      end
    end while (resp_valid[d] !== 1'b1 && lat < 20);
    check($sformatf("latency_d%0d", d), 64'(lat), 64'(lat_of[d]));
  endtask

  task automatic consume(input int d);
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    check($sformatf("ready_after_consume_d%0d", d), {63'd0, req_ready[d]}, 64'd1);
    check($sformatf("valid_after_consume_d%0d", d), {63'd0, resp_valid[d]}, 64'd0);
  endtask

  task automatic run_vec(input int d, input vec_t v);
    issue(d, v.wen, v.sgn, v.size, v.addr, v.wdata);
    wait_resp(d);
    check({v.name, "_rdata"}, resp_rdata[d], v.exp_rdata);
    check({v.name, "_err"}, {63'd0, resp_err[d]}, {63'd0, v.exp_err});
    consume(d);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_resp_valid_d%0d", tag, d), {63'd0, resp_valid[d]}, 64'd0);
      check($sformatf("%s_resp_rdata_d%0d", tag, d), resp_rdata[d], 64'd0);
      check($sformatf("%s_resp_err_d%0d", tag, d), {63'd0, resp_err[d]}, 64'd0);
      check($sformatf("%s_req_ready_d%0d", tag, d), {63'd0, req_ready[d]}, 64'd0);
      check($sformatf("%s_state_d%0d", tag, d), {62'd0, state[d]}, 64'd0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      check($sformatf("ready_after_reset_d%0d", d), {63'd0, req_ready[d]}, 64'd1);
  endtask

  initial begin
    // Vectors for the 64-bit instance
    v64.push_back(mk("st_d10",   1, 0, 3, 64'h10, 64'h1122334455667788, 64'h0, 0));
    v64.push_back(mk("ld_d10",   0, 0, 3, 64'h10, 64'h0, 64'h1122334455667788, 0));
    v64.push_back(mk("ld_b17s",  0, 1, 0, 64'h17, 64'h0, 64'h11, 0));
    v64.push_back(mk("st_b11",   1, 0, 0, 64'h11, 64'h12345680, 64'h0, 0));
    v64.push_back(mk("ld_b11s",  0, 1, 0, 64'h11, 64'h0, 64'hFFFFFFFFFFFFFF80, 0));
    v64.push_back(mk("ld_b11u",  0, 0, 0, 64'h11, 64'h0, 64'h80, 0));
    v64.push_back(mk("ld_d10s",  0, 1, 3, 64'h10, 64'h0, 64'h1122334455668088, 0));
    v64.push_back(mk("ld_h13",   0, 0, 1, 64'h13, 64'h0, 64'h0, 1));
    v64.push_back(mk("st_d00",   1, 0, 3, 64'h0, 64'h0123456789ABCDEF, 64'h0, 0));
    v64.push_back(mk("st_w_oor", 1, 0, 2, 64'h2000, 64'hDEADBEEF, 64'h0, 1));
    v64.push_back(mk("ld_d00",   0, 0, 3, 64'h0, 64'h0, 64'h0123456789ABCDEF, 0));
    v64.push_back(mk("ld_d14",   0, 0, 3, 64'h14, 64'h0, 64'h0, 1));
    v64.push_back(mk("ld_b_hi",  0, 0, 0, 64'h0001000000000010, 64'h0, 64'h0, 1));
    v64.push_back(mk("st_h18",   1, 0, 1, 64'h18, 64'hF00D, 64'h0, 0));
    v64.push_back(mk("ld_h18s",  0, 1, 1, 64'h18, 64'h0, 64'hFFFFFFFFFFFFF00D, 0));
    v64.push_back(mk("ld_h18u",  0, 0, 1, 64'h18, 64'h0, 64'hF00D, 0));
    v64.push_back(mk("ld_b19u",  0, 0, 0, 64'h19, 64'h0, 64'hF0, 0));
    v64.push_back(mk("st_w2c",   1, 0, 2, 64'h2C, 64'h89ABCDEF, 64'h0, 0));
    v64.push_back(mk("ld_w2cs",  0, 1, 2, 64'h2C, 64'h0, 64'hFFFFFFFF89ABCDEF, 0));
    v64.push_back(mk("ld_w2cu",  0, 0, 2, 64'h2C, 64'h0, 64'h0000000089ABCDEF, 0));
    v64.push_back(mk("ld_h16s",  0, 1, 1, 64'h16, 64'h0, 64'h1122, 0));
    v64.push_back(mk("ld_w14u",  0, 0, 2, 64'h14, 64'h0, 64'h11223344, 0));

    // Vectors for the 32-bit instances
    v32.push_back(mk("w_st_w10",   1, 0, 2, 64'h10, 64'h55667788, 64'h0, 0));
    v32.push_back(mk("w_ld_w10",   0, 0, 2, 64'h10, 64'h0, 64'h55667788, 0));
    v32.push_back(mk("w_ld_b13s",  0, 1, 0, 64'h13, 64'h0, 64'h55, 0));
    v32.push_back(mk("w_st_b11",   1, 0, 0, 64'h11, 64'h12345680, 64'h0, 0));
    v32.push_back(mk("w_ld_b11s",  0, 1, 0, 64'h11, 64'h0, 64'hFFFFFF80, 0));
    v32.push_back(mk("w_ld_b11u",  0, 0, 0, 64'h11, 64'h0, 64'h80, 0));
    v32.push_back(mk("w_ld_w10s",  0, 1, 2, 64'h10, 64'h0, 64'h55668088, 0));
    v32.push_back(mk("w_ld_h13",   0, 0, 1, 64'h13, 64'h0, 64'h0, 1));
    v32.push_back(mk("w_st_w00",   1, 0, 2, 64'h0, 64'h01234567, 64'h0, 0));
    v32.push_back(mk("w_st_w_oor", 1, 0, 2, 64'h1000, 64'hDEADBEEF, 64'h0, 1));
    v32.push_back(mk("w_ld_w00",   0, 0, 2, 64'h0, 64'h0, 64'h01234567, 0));
    v32.push_back(mk("w_ld_d10",   0, 0, 3, 64'h10, 64'h0, 64'h0, 1));
    v32.push_back(mk("w_st_d10",   1, 0, 3, 64'h10, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1));
    v32.push_back(mk("w_ld_w10b",  0, 0, 2, 64'h10, 64'h0, 64'h55668088, 0));
    v32.push_back(mk("w_ld_h12s",  0, 1, 1, 64'h12, 64'h0, 64'h5566, 0));
    v32.push_back(mk("w_st_h12",   1, 0, 1, 64'h12, 64'h9ABC, 64'h0, 0));
    v32.push_back(mk("w_ld_h12s2", 0, 1, 1, 64'h12, 64'h0, 64'hFFFF9ABC, 0));
    v32.push_back(mk("w_ld_w10c",  0, 0, 2, 64'h10, 64'h0, 64'h9ABC8088, 0));

    // Clock/reset block
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_signed[d] = 1'b0;
      req_size[d] = 2'd0; req_addr[d] = 64'd0; req_wdata[d] = 64'd0;
      resp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();

    // Main table, 64-bit instance
    foreach (v64[i]) run_vec(0, v64[i]);

    // Hold the response for 5 cycles while a new request waits
    issue(0, 1'b0, 1'b0, 2'd3, 64'h10, 64'h0);
    wait_resp(0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_signed[0] = 1'b0;
    req_size[0] = 2'd0; req_addr[0] = 64'h10; req_wdata[0] = 64'h0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_valid_%0d", k), {63'd0, resp_valid[0]}, 64'd1);
      check($sformatf("hold_rdata_%0d", k), resp_rdata[0], 64'h1122334455668088);
      check($sformatf("hold_err_%0d", k), {63'd0, resp_err[0]}, 64'd0);
      check($sformatf("hold_req_ready_%0d", k), {63'd0, req_ready[0]}, 64'd0);
    end
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[0] = 1'b0;
    check("hold_release_state", {62'd0, state[0]}, 64'd0);
    check("hold_release_ready", {63'd0, req_ready[0]}, 64'd1);
    check("hold_release_valid", {63'd0, resp_valid[0]}, 64'd0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    check("reaccept_state", {62'd0, state[0]}, 64'd1);
    wait_resp(0);
    check("reaccept_rdata", resp_rdata[0], 64'h88);
    consume(0);

    // Reset during BUSY aborts a pending store
    run_vec(0, mk("st_d20_zero", 1, 0, 3, 64'h20, 64'h0, 64'h0, 0));
    issue(0, 1'b1, 1'b0, 2'd0, 64'h20, 64'hAA);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_busy");
    repeat (2) @(posedge clk);
    release_reset();
    run_vec(0, mk("ld_b20_after_abort", 0, 0, 0, 64'h20, 64'h0, 64'h0, 0));

    // Reset during RESP drops the response
    issue(0, 1'b0, 1'b0, 2'd3, 64'h10, 64'h0);
    wait_resp(0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_resp_valid", {63'd0, resp_valid[0]}, 64'd0);
    check("abort_resp_rdata", resp_rdata[0], 64'd0);
    check("abort_resp_state", {62'd0, state[0]}, 64'd0);
    repeat (2) @(posedge clk);
    release_reset();

    // 32-bit instances with LATENCY 1 and 4
    foreach (v32[i]) run_vec(1, v32[i]);
    foreach (v32[i]) run_vec(2, v32[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
